// File: rtl/dnn_argmax_stream.sv
// dnn_argmax_stream: streaming argmax with runner-up tracking for the DNN output layer.
// Takes one signed score per beat, tracks the best and runner-up classes as
// they stream in, and on the last beat presents a held result record.
//
// Ports
//   clk, rst         clock and synchronous active-high reset
//   s_valid/s_ready  score stream handshake; s_data signed score, s_last ends vector
//   margin_thresh    unsigned confidence threshold, sampled on beat 0 of a vector
//   m_valid/m_ready  result handshake; outputs stay stable until accepted
//   m_index, m_max   winning class and its score
//   m_second_index   runner-up class
//   m_margin         m_max minus runner-up score (DATA_W+1 bits, unsigned)
//   m_low_conf       m_margin below the sampled threshold
//   m_len_err        vector length differed from NUM_CLASSES
module dnn_argmax_stream #(
   parameter  int unsigned NUM_CLASSES = 10,
   parameter  int unsigned DATA_W      = 16,
   localparam int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic [DATA_W:0]   margin_thresh,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [IDX_W-1:0]  m_index,
   output logic [DATA_W-1:0] m_max,
   output logic [IDX_W-1:0]  m_second_index,
   output logic [DATA_W:0]   m_margin,
   output logic              m_low_conf,
   output logic              m_len_err
);

   // Counter must be able to hold NUM_CLASSES itself (saturation value).
   localparam int unsigned CNT_W = $clog2(NUM_CLASSES + 1);
   localparam int unsigned MRG_W = DATA_W + 1;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic signed [DATA_W-1:0]  best_q, best_d;
   logic [IDX_W-1:0]          best_idx_q, best_idx_d;
   logic signed [DATA_W-1:0]  second_q, second_d;
   logic [IDX_W-1:0]          second_idx_q, second_idx_d;
   logic                      second_vld_q, second_vld_d;
   logic [MRG_W-1:0]          thresh_q, thresh_d;

   logic [IDX_W-1:0]          m_index_q, m_index_d;
   logic [DATA_W-1:0]         m_max_q, m_max_d;
   logic [IDX_W-1:0]          m_second_index_q, m_second_index_d;
   logic [MRG_W-1:0]          m_margin_q, m_margin_d;
   logic                      m_low_conf_q, m_low_conf_d;
   logic                      m_len_err_q, m_len_err_d;

   logic signed [DATA_W-1:0]  s_score;
   logic                      xfer;
   logic [IDX_W-1:0]          beat_idx;
   logic                      in_range;
   logic [MRG_W-1:0]          diff_c;

   assign s_score  = $signed(s_data);
   assign s_ready  = (state_q == ST_ACCUM) && !rst;
   assign xfer     = s_valid && s_ready;
   assign in_range = (cnt_q < CNT_W'(NUM_CLASSES));
   assign beat_idx = IDX_W'(cnt_q);

   // Next-state, running best/runner-up update and result load.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      best_d           = best_q;
      best_idx_d       = best_idx_q;
      second_d         = second_q;
      second_idx_d     = second_idx_q;
      second_vld_d     = second_vld_q;
      thresh_d         = thresh_q;
      m_index_d        = m_index_q;
      m_max_d          = m_max_q;
      m_second_index_d = m_second_index_q;
      m_margin_d       = m_margin_q;
      m_low_conf_d     = m_low_conf_q;
      m_len_err_d      = m_len_err_q;
      diff_c           = '0;

      unique case (state_q)
         ST_ACCUM: begin
            if (xfer) begin
               if (cnt_q == '0) begin
                  best_d       = s_score;
                  best_idx_d   = '0;
                  second_vld_d = 1'b0;
                  thresh_d     = margin_thresh;
               end else if (in_range) begin
                  if (s_score > best_q) begin
                     // New leader; the old leader becomes runner-up.
                     second_d     = best_q;
                     second_idx_d = best_idx_q;
                     second_vld_d = 1'b1;
                     best_d       = s_score;
                     best_idx_d   = beat_idx;
                  end else if (!second_vld_q || (s_score > second_q)) begin
                     second_d     = s_score;
                     second_idx_d = beat_idx;
                     second_vld_d = 1'b1;
                  end
               end

               // Saturating beat counter; beats past NUM_CLASSES are ignored.
               if (in_range) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end

               if (s_last) begin
                  // Result reflects the state including this final beat.
                  m_index_d = best_idx_d;
                  m_max_d   = best_d;
                  if (second_vld_d) begin
                     // Sign-extended subtract; best >= second so result is non-negative.
                     diff_c           = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
                     m_second_index_d = second_idx_d;
                     m_margin_d       = diff_c;
                  end else begin
                     m_second_index_d = best_idx_d;
                     m_margin_d       = '0;
                  end
                  m_low_conf_d = (m_margin_d < thresh_d);
                  // Exactly NUM_CLASSES beats means this one is index NUM_CLASSES-1.
                  m_len_err_d  = (cnt_q != CNT_W'(NUM_CLASSES - 1));
                  state_d      = ST_HOLD;
               end
            end
         end

         ST_HOLD: begin
            if (m_ready) begin
               state_d = ST_ACCUM;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_ACCUM;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= ST_ACCUM;
         cnt_q            <= '0;
         best_q           <= '0;
         best_idx_q       <= '0;
         second_q         <= '0;
         second_idx_q     <= '0;
         second_vld_q     <= 1'b0;
         thresh_q         <= '0;
         m_index_q        <= '0;
         m_max_q          <= '0;
         m_second_index_q <= '0;
         m_margin_q       <= '0;
         m_low_conf_q     <= 1'b0;
         m_len_err_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         best_q           <= best_d;
         best_idx_q       <= best_idx_d;
         second_q         <= second_d;
         second_idx_q     <= second_idx_d;
         second_vld_q     <= second_vld_d;
         thresh_q         <= thresh_d;
         m_index_q        <= m_index_d;
         m_max_q          <= m_max_d;
         m_second_index_q <= m_second_index_d;
         m_margin_q       <= m_margin_d;
         m_low_conf_q     <= m_low_conf_d;
         m_len_err_q      <= m_len_err_d;
      end
   end

   assign m_valid        = (state_q == ST_HOLD);
   assign m_index        = m_index_q;
   assign m_max          = m_max_q;
   assign m_second_index = m_second_index_q;
   assign m_margin       = m_margin_q;
   assign m_low_conf     = m_low_conf_q;
   assign m_len_err      = m_len_err_q;

endmodule

// File: tb/tb_dnn_argmax_stream.sv
// Bench for dnn_argmax_stream: directed vectors, a whole-vector argmax model
// and a per-cycle compare process, plus hand-computed literal expectations.
module tb_dnn_argmax_stream;

   localparam int unsigned NC = 10;
   localparam int unsigned DW = 16;
   localparam int unsigned IW = $clog2(NC);
   localparam int unsigned MW = DW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic [MW-1:0] margin_thresh;
   logic          m_valid;
   logic          m_ready;
   logic [IW-1:0] m_index;
   logic [DW-1:0] m_max;
   logic [IW-1:0] m_second_index;
   logic [MW-1:0] m_margin;
   logic          m_low_conf;
   logic          m_len_err;

   dnn_argmax_stream #(.NUM_CLASSES(NC), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .margin_thresh(margin_thresh),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_index(m_index), .m_max(m_max), .m_second_index(m_second_index),
      .m_margin(m_margin), .m_low_conf(m_low_conf), .m_len_err(m_len_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int mx;
      int sidx;
      int margin;
      bit low;
      bit len;
   } res_t;

   res_t exp_q[$];
   int   cur[$];
   int   cur_thr;
   int   stim[$];
   int   n_err = 0;
   int   n_chk = 0;
   bit   started = 1'b0;
   time  hs_t = 0;
   time  xfer_t = 0;
   time  vec_start_t = 0;

   task automatic chk(input string nm, input longint act, input longint ex);
      n_chk++;
      if (act != ex) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
      end
   endtask

   // Whole-vector reference: argmax over the first NC scores, runner-up is
   // the best of the remaining ones, lowest index winning every tie.
   function automatic res_t model_cur();
      res_t r;
      int n = cur.size();
      int k = (n < int'(NC)) ? n : int'(NC);
      r.idx = 0;
      for (int i = 1; i < k; i++) if (cur[i] > cur[r.idx]) r.idx = i;
      r.mx = cur[r.idx];
      if (k < 2) begin
         r.sidx   = r.idx;
         r.margin = 0;
      end else begin
         r.sidx = -1;
         for (int i = 0; i < k; i++)
            if (i != r.idx && (r.sidx < 0 || cur[i] > cur[r.sidx])) r.sidx = i;
         r.margin = cur[r.idx] - cur[r.sidx];
      end
      r.low = (r.margin < cur_thr);
      r.len = (n != int'(NC));
      return r;
   endfunction

   // Per-cycle compare against the model's pending results.
   always @(negedge clk) begin
      if (started && !rst) begin
         chk("s_ready", longint'(s_ready), longint'(exp_q.size() == 0));
         chk("m_valid", longint'(m_valid), longint'(exp_q.size() != 0));
         if (m_valid && exp_q.size() != 0) begin
            chk("m_index",        longint'(m_index),          longint'(exp_q[0].idx));
            chk("m_max",          longint'($signed(m_max)),   longint'(exp_q[0].mx));
            chk("m_second_index", longint'(m_second_index),   longint'(exp_q[0].sidx));
            chk("m_margin",       longint'(m_margin),         longint'(exp_q[0].margin));
            chk("m_low_conf",     longint'(m_low_conf),       longint'(exp_q[0].low));
            chk("m_len_err",      longint'(m_len_err),        longint'(exp_q[0].len));
            if (m_ready) begin
               void'(exp_q.pop_front());
               hs_t = $time + 5;
            end
         end
      end
   end

   // One beat; returns just after the transferring posedge.
   task automatic beat(input int d, input bit last, input int thr);
      bit ok = 1'b0;
      int guard = 0;
      s_valid       = 1'b1;
      s_data        = DW'(d);
      s_last        = last;
      margin_thresh = MW'(thr);
      while (!ok && guard < 100) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk);
         guard++;
      end
      if (!ok) begin
         chk("beat_timeout", 0, 1);
      end else begin
         xfer_t = $time;
         if (cur.size() == 0) cur_thr = thr;
         cur.push_back(d);
         if (last) begin
            exp_q.push_back(model_cur());
            cur.delete();
         end
      end
      #1;
   endtask

   // Sends stim; threshold is garbage after beat 0 to show it is latched.
   task automatic send_vec(input int thr, input int gap);
      for (int i = 0; i < stim.size(); i++) begin
         beat(stim[i], i == stim.size() - 1, (i == 0) ? thr : (thr ^ 32'h1FFFF));
         if (i == 0) vec_start_t = xfer_t;
         if (gap > 0 && (i % 3) == 1 && i != stim.size() - 1) begin
            s_valid = 1'b0;
            s_data  = DW'($urandom);
            s_last  = 1'b1;
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic lit(input string p, input int idx, input int mx, input int sidx,
                      input int mrg, input int low, input int len);
      chk({p, "_valid"},  longint'(m_valid),        1);
      chk({p, "_index"},  longint'(m_index),        idx);
      chk({p, "_max"},    longint'($signed(m_max)), mx);
      chk({p, "_sindex"}, longint'(m_second_index), sidx);
      chk({p, "_margin"}, longint'(m_margin),       mrg);
      chk({p, "_low"},    longint'(m_low_conf),     low);
      chk({p, "_len"},    longint'(m_len_err),      len);
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_valid"},  longint'(m_valid),        0);
      chk({p, "_index"},  longint'(m_index),        0);
      chk({p, "_max"},    longint'(m_max),          0);
      chk({p, "_sindex"}, longint'(m_second_index), 0);
      chk({p, "_margin"}, longint'(m_margin),       0);
      chk({p, "_low"},    longint'(m_low_conf),     0);
      chk({p, "_len"},    longint'(m_len_err),      0);
      chk({p, "_ready"},  longint'(s_ready),        1);
   endtask

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      margin_thresh = '0; m_ready = 1'b1;
      @(negedge clk);
      chk("rst_s_ready", longint'(s_ready), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      started = 1'b1;
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;

      // Tie on best: index 2 wins, index 4 is runner-up, zero margin.
      stim = '{3, -7, 12, 5, 12, 0, -1, 8, 2, 11};
      send_vec(2, 0);
      @(negedge clk);
      lit("t1", 2, 12, 4, 0, 1, 0);
      @(posedge clk); #1;

      // All minimum scores, with idle gaps.
      stim = {};
      repeat (10) stim.push_back(-32768);
      send_vec(0, 2);
      @(negedge clk);
      lit("t2", 0, -32768, 1, 0, 0, 0);
      @(posedge clk); #1;

      // Full-range margin, then backpressure.
      m_ready = 1'b0;
      stim = {};
      stim.push_back(32767);
      repeat (9) stim.push_back(-32768);
      send_vec(65535, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("t3_hold_ready", longint'(s_ready), 0);
         lit("t3_hold", 0, 32767, 1, 65535, 0, 0);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      stim = '{-5, 4, 4, -1, 0, 9, 9, -9, 3, 2};
      send_vec(1, 0);
      chk("t3_b2b_start", longint'(vec_start_t - hs_t), 10);
      @(negedge clk);
      lit("t3b", 5, 9, 6, 0, 1, 0);
      @(posedge clk); #1;

      // Short vector.
      stim = '{1, 2, 3, 4, 5, 6, 7};
      send_vec(0, 0);
      @(negedge clk);
      lit("t4", 6, 7, 5, 1, 0, 1);
      @(posedge clk); #1;

      // Long vector; trailing large scores must be ignored.
      stim = '{1, -2, 0, 5, 4, -3, 2, 5, 3, -1, 32767, 32767};
      send_vec(3, 1);
      @(negedge clk);
      lit("t5", 3, 5, 7, 0, 1, 1);
      @(posedge clk); #1;

      // Reset mid-vector discards the partial vector.
      beat(9, 1'b0, 0);
      beat(8, 1'b0, 0);
      beat(7, 1'b0, 0);
      beat(6, 1'b0, 0);
      s_valid = 1'b0;
      rst = 1'b1;
      cur.delete();
      @(negedge clk);
      chk("t6_rst_ready", longint'(s_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_zero("t6_post");
      repeat (2) @(negedge clk);
      chk("t6_idle_valid", longint'(m_valid), 0);
      @(posedge clk); #1;
      stim = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      send_vec(0, 0);
      @(negedge clk);
      lit("t6", 9, 9, 8, 1, 0, 0);
      @(posedge clk); #1;

      repeat (3) @(posedge clk);
      chk("drain", longint'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dnn_argmax_stream.md
# dnn_argmax_stream

Streaming, parametrised classifier output stage for the DNN pipeline. It accepts one signed score per cycle from the output layer over a valid/ready stream and tracks the best and runner-up class. Once the vector completes, it presents the winning index, its score, the runner-up index, the exact margin between them, a low-confidence flag and a length-error flag on a held valid/ready result port. It replaces the fixed 10-way, 4-bit, single-cycle argmax with arbitrary class count and score width plus backpressure.

## Interface
- NUM_CLASSES, 10, number of scores per vector (>=2); IDX_W = $clog2(NUM_CLASSES) derived locally
- DATA_W, 16, signed score width; margin width is DATA_W+1
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset: one clock; reset is synchronous and active-high
- s_valid  in  1  score beat valid
- s_ready  out  1  block accepts score beat
- s_data  in  DATA_W  signed score
- s_last  in  1  final beat of the vector
- margin_thresh  in  DATA_W+1  unsigned confidence threshold, sampled on the first beat of each vector
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_index  out  IDX_W  winning class index
- m_max  out  DATA_W  winning score
- m_second_index  out  IDX_W  runner-up class index
- m_margin  out  DATA_W+1  unsigned m_max minus runner-up score
- m_low_conf  out  1  m_margin < sampled threshold
- m_len_err  out  1  vector length != NUM_CLASSES

## Operation
- FSM states: ACCUM and HOLD. Reset enters ACCUM with the beat counter at 0.
- s_ready = (state==ACCUM) && !rst. m_valid = (state==HOLD).
- Beats:
  - A beat transfers when s_valid && s_ready. The beat index is the counter value; the counter increments per beat and saturates at NUM_CLASSES.
  - Beat 0: best=s_data, best_idx=0, second invalid, threshold latched.
  - Beat i<NUM_CLASSES with s_data > best (strict, signed): second<=best, second_idx<=best_idx, best<=s_data, best_idx<=i.
  - Otherwise, if second is invalid or s_data > second (strict): second<=s_data, second_idx<=i.
  - Ties therefore resolve to the lowest index for both best and runner-up. A score equal to best becomes runner-up if it beats the current second.
- Beats with index >= NUM_CLASSES are consumed without comparison and set the length error.
- Beat with s_last: the result registers load and the state goes to HOLD.
  - len_err = (beats received != NUM_CLASSES).
  - If only one beat was received: second_idx=best_idx, margin=0.
- Margin = best - second computed at DATA_W+1 bits. It is never negative, and no overflow is possible.
- low_conf = margin < latched threshold, unsigned compare.
- HOLD: all m_* outputs stay stable until m_valid && m_ready. On that handshake the next state is ACCUM and the counter clears.
- rst asserted in any state, including mid-vector or during HOLD:
  - the partial vector is discarded;
  - the state returns to ACCUM;
  - all registered outputs clear.

## Timing
- Reset values: m_valid 0, m_index 0, m_max 0, m_second_index 0, m_margin 0, m_low_conf 0, m_len_err 0. s_ready is 0 while rst is high and 1 on the first cycle after.
- Comparison is registered per beat, with no combinational path from s_data to outputs.
- Latency: m_valid rises on the cycle after the s_last beat transfers.
- Throughput: one vector per NUM_CLASSES+1 cycles when m_ready is held high. There is a single bubble cycle, in HOLD, between vectors.
- s_ready returns high on the cycle after the result handshake. s_ready is never high while m_valid is high.
- Idle gaps (s_valid low) in ACCUM are allowed at any point and do not affect the result.

## Test plan
- Scores [3,-7,12,5,12,0,-1,8,2,11], thresh 2: m_index 2, m_max 12, m_second_index 4, m_margin 0, m_low_conf 1, m_len_err 0, m_valid one cycle after the last beat.
- All ten scores -32768, thresh 0: m_index 0, m_second_index 1, m_margin 0, m_low_conf 0.
- Scores [32767,-32768 x9], thresh 65535: m_margin 65535, m_low_conf 0.
  - Then hold m_ready low for 5 cycles: outputs stable and s_ready 0 throughout.
  - A second vector driven back-to-back is accepted starting the cycle after the handshake.
- s_last on beat 7 (scores 1..7): m_index 6, m_len_err 1.
- 12 beats with 32767 on beats 10 and 11 and max 5 at index 3: m_index 3, m_max 5, m_len_err 1.
- rst pulsed for one cycle after 4 beats of a vector: m_valid stays 0 and outputs are zero. A following full vector [0,1,…,9] yields m_index 9, m_second_index 8, m_margin 1.
